// File: rtl/fifo_sc_if.sv
// fifo_sc_if: handshake, data and status bundle between a producer/consumer
// (master) and the single-clock FIFO (slave). Clock and reset stay plain ports.
interface fifo_sc_if #(
    parameter int W = 8,
    parameter int N = 4
);
    logic         clr;
    logic         we;
    logic [W-1:0] wd;
    logic         re;
    logic [W-1:0] rd;
    logic         rempty;
    logic         wfull;
    logic [N:0]   usedw;
    logic         almost_full;
    logic         almost_empty;
    logic         overflow;
    logic         underflow;

    modport master (
        output clr, we, wd, re,
        input  rd, rempty, wfull, usedw, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  clr, we, wd, re,
        output rd, rempty, wfull, usedw, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_sc.sv
// fifo_sc: single-clock synchronous FIFO, 2**N words of W bits, with fill
// level, almost-full/almost-empty flags, synchronous flush and sticky
// overflow/underflow flags. All status outputs are registered.
// Optional build macro FIFO_SHOWAHEAD_EN selects first-word-fall-through:
// rd presents the head word whenever the FIFO is non-empty.
module fifo_sc #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int AF = (2 ** N) - 2,
    parameter int AE = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    fifo_sc_if.slave bus
);
    localparam int         D    = 2 ** N;
    localparam logic [N:0] AF_V = AF[N:0];
    localparam logic [N:0] AE_V = AE[N:0];

    logic [W-1:0] mem [D];

    logic [N:0]   wptr_q, wptr_d;
    logic [N:0]   rptr_q, rptr_d;
    logic [N:0]   usedw_q, usedw_d;
    logic         rempty_q, rempty_d;
    logic         wfull_q, wfull_d;
    logic         af_q, af_d;
    logic         ae_q, ae_d;
    logic         ovf_q, ovf_d;
    logic         udf_q, udf_d;
    logic [W-1:0] rd_q, rd_d;

    logic wa;
    logic ra;

    // Accept decisions; a flush cycle ignores both requests entirely.
    assign wa = bus.we & ~wfull_q  & ~bus.clr;
    assign ra = bus.re & ~rempty_q & ~bus.clr;

    // Next-state: pointers, level, flags and read data, all from registered state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        rd_d   = rd_q;
        ovf_d  = ovf_q | (bus.we & wfull_q  & ~bus.clr);
        udf_d  = udf_q | (bus.re & rempty_q & ~bus.clr);

        if (bus.clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            wptr_d = wptr_q + {{N{1'b0}}, wa};
            rptr_d = rptr_q + {{N{1'b0}}, ra};
        end

        // Pointer difference modulo 2*D is the fill level, 0..D.
        usedw_d  = wptr_d - rptr_d;
        rempty_d = (wptr_d == rptr_d);
        wfull_d  = (wptr_d[N-1:0] == rptr_d[N-1:0]) && (wptr_d[N] != rptr_d[N]);
        af_d     = (usedw_d >= AF_V);
        ae_d     = (usedw_d <= AE_V);

`ifdef FIFO_SHOWAHEAD_EN
        // Output stage tracks the next head word. When that word is being
        // written on this same edge, it is bypassed from wd.
        if (!bus.clr) begin
            if (wa && (rptr_d[N-1:0] == wptr_q[N-1:0])) begin
                rd_d = bus.wd;
            end else if (!rempty_d) begin
                rd_d = mem[rptr_d[N-1:0]];
            end
        end
`else
        if (ra) begin
            rd_d = mem[rptr_q[N-1:0]];
        end
`endif
    end

    // State register with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            usedw_q  <= '0;
            rempty_q <= 1'b1;
            wfull_q  <= 1'b0;
            af_q     <= (AF_V == '0);
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            usedw_q  <= usedw_d;
            rempty_q <= rempty_d;
            wfull_q  <= wfull_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rd_q     <= rd_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto RAM; emptiness is tracked by the pointers.
        if (rst_n && wa) begin
            mem[wptr_q[N-1:0]] <= bus.wd;
        end
    end

    assign bus.rd           = rd_q;
    assign bus.rempty       = rempty_q;
    assign bus.wfull        = wfull_q;
    assign bus.usedw        = usedw_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sc.sv
// tb_fifo_sc: directed self-checking bench for fifo_sc with W=4, N=2, AF=3, AE=1.
module tb_fifo_sc;
    localparam int W = 4;
    localparam int N = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    fifo_sc_if #(.W(W), .N(N)) bus ();

    fifo_sc #(.W(W), .N(N), .AF(3), .AE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, sample 1 ns after the edge.
    task automatic cyc(input logic w, input logic [W-1:0] d, input logic r, input logic c);
        bus.we  = w;
        bus.wd  = d;
        bus.re  = r;
        bus.clr = c;
        @(posedge clk);
        #1;
        bus.we  = 1'b0;
        bus.re  = 1'b0;
        bus.clr = 1'b0;
    endtask

    // Pop one word and check it appears on rd where the read mode puts it.
    task automatic do_read(input logic [W-1:0] exp, input string tag);
`ifdef FIFO_SHOWAHEAD_EN
        check(tag, bus.rd, exp);
        cyc(1'b0, '0, 1'b1, 1'b0);
`else
        cyc(1'b0, '0, 1'b1, 1'b0);
        check(tag, bus.rd, exp);
`endif
    endtask

    task automatic fill4();
        cyc(1'b1, 4'h1, 1'b0, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0);
        cyc(1'b1, 4'h4, 1'b0, 1'b0);
        cyc(1'b1, 4'h8, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] wv [4];
        logic [W-1:0] rd_before;
        wv[0] = 4'h1; wv[1] = 4'h2; wv[2] = 4'h4; wv[3] = 4'h8;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.we   = 1'b0;
        bus.wd   = '0;
        bus.re   = 1'b0;
        bus.clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1. Reset state.
        check("rst_rempty", bus.rempty, 1);
        check("rst_wfull", bus.wfull, 0);
        check("rst_usedw", bus.usedw, 0);
        check("rst_ae", bus.almost_empty, 1);
        check("rst_af", bus.almost_full, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_udf", bus.underflow, 0);
        check("rst_rd", bus.rd, 0);

        // 2. Fill with 1,2,4,8, then drain.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, wv[i], 1'b0, 1'b0);
            check("s2_usedw", bus.usedw, i + 1);
            check("s2_af", bus.almost_full, (i + 1 >= 3) ? 1 : 0);
            check("s2_ae", bus.almost_empty, (i + 1 <= 1) ? 1 : 0);
            check("s2_wfull", bus.wfull, (i == 3) ? 1 : 0);
            check("s2_rempty", bus.rempty, 0);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(wv[i], "s2_rd");
            check("s2_rd_usedw", bus.usedw, 3 - i);
        end
        check("s2_end_rempty", bus.rempty, 1);
        check("s2_end_ovf", bus.overflow, 0);
        check("s2_end_udf", bus.underflow, 0);

        // 3. Overflow: write while full is rejected and sticky flag set.
        fill4();
        cyc(1'b1, 4'hF, 1'b0, 1'b0);
        check("s3_usedw", bus.usedw, 4);
        check("s3_wfull", bus.wfull, 1);
        check("s3_ovf", bus.overflow, 1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("s3_ovf_sticky", bus.overflow, 1);
        for (int i = 0; i < 4; i++) begin
            do_read(wv[i], "s3_rd");
        end
        check("s3_rempty", bus.rempty, 1);
        check("s3_udf", bus.underflow, 0);

        // 4. Write and read together on empty: read rejected, underflow set.
        cyc(1'b1, 4'h5, 1'b1, 1'b0);
        check("s4_udf", bus.underflow, 1);
        check("s4_usedw", bus.usedw, 1);
        check("s4_rempty", bus.rempty, 0);
        do_read(4'h5, "s4_rd");
        check("s4_usedw0", bus.usedw, 0);

        // 5. Streaming 3..8 with concurrent reads; pointers wrap.
        cyc(1'b1, 4'h3, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
`ifdef FIFO_SHOWAHEAD_EN
            check("s5_rd", bus.rd, 3 + k - 1);
`endif
            cyc(1'b1, 4'(3 + k), 1'b1, 1'b0);
            check("s5_usedw", bus.usedw, 1);
`ifndef FIFO_SHOWAHEAD_EN
            check("s5_rd", bus.rd, 3 + k - 1);
`endif
        end
        do_read(4'h8, "s5_rd_last");
        check("s5_rempty", bus.rempty, 1);

        // 6. Flush with level 3, then reset pulse, then a fresh write.
        cyc(1'b1, 4'h1, 1'b0, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0);
        cyc(1'b1, 4'h3, 1'b0, 1'b0);
        check("s6_usedw3", bus.usedw, 3);
        check("s6_af", bus.almost_full, 1);
`ifdef FIFO_SHOWAHEAD_EN
        rd_before = 4'h1;
`else
        rd_before = 4'h8;
`endif
        cyc(1'b1, 4'hA, 1'b1, 1'b1);
        check("s6_clr_usedw", bus.usedw, 0);
        check("s6_clr_rempty", bus.rempty, 1);
        check("s6_clr_af", bus.almost_full, 0);
        check("s6_clr_ae", bus.almost_empty, 1);
        check("s6_clr_ovf", bus.overflow, 1);
        check("s6_clr_udf", bus.underflow, 1);
        check("s6_clr_rd", bus.rd, rd_before);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("s6_clr_hold", bus.usedw, 0);

        rst_n = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("s6_rst_ovf", bus.overflow, 0);
        check("s6_rst_udf", bus.underflow, 0);
        check("s6_rst_rd", bus.rd, 0);

        cyc(1'b1, 4'h9, 1'b0, 1'b0);
        check("s6_w_rempty", bus.rempty, 0);
        check("s6_w_usedw", bus.usedw, 1);
        do_read(4'h9, "s6_rd");
        check("s6_end_rempty", bus.rempty, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
